// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops bytes while the FIFO is not empty and packs PACK of them
// into one wide word on a valid/ready output. A stalled partial word is flushed after TIMEOUT idle cycles.
module fifo_rd_packer #(
   parameter int unsigned data_width = 8,
   parameter int unsigned PACK       = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                         rclk,
   input  logic                         r_rst_n,
   input  logic                         rempty,
   input  logic [data_width-1:0]        rdata,
   output logic                         rinc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PACK*data_width-1:0]   out_data,
   output logic [PACK-1:0]              out_keep,
   output logic [15:0]                  word_cnt
);

   localparam int unsigned DW = PACK * data_width;
   localparam int unsigned CW = $clog2(PACK) + 1;
   localparam int unsigned IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [0:0]    r_state,    w_state;
   logic [CW-1:0] r_count,    w_count;
   logic [IW-1:0] r_idle,     w_idle;
   logic [DW-1:0] r_data,     w_data;
   logic [PACK-1:0] r_keep,   w_keep;
   logic [15:0]   r_word_cnt, w_word_cnt;
   logic [IW-1:0] w_idle_inc;

   // Pop is gated by reset so nothing leaves the FIFO while the packer is held in reset.
   assign rinc = r_rst_n && !rempty &&
                 ((r_state == S_FILL) || ((r_state == S_HOLD) && out_ready));

   assign out_valid = (r_state == S_HOLD);
   assign out_data  = r_data;
   assign out_keep  = r_keep;
   assign word_cnt  = r_word_cnt;

   always_ff @(posedge rclk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_state    <= S_FILL;
         r_count    <= '0;
         r_idle     <= '0;
         r_data     <= '0;
         r_keep     <= '0;
         r_word_cnt <= '0;
      end else begin
         r_state    <= w_state;
         r_count    <= w_count;
         r_idle     <= w_idle;
         r_data     <= w_data;
         r_keep     <= w_keep;
         r_word_cnt <= w_word_cnt;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_count    = r_count;
      w_idle     = r_idle;
      w_data     = r_data;
      w_keep     = r_keep;
      w_word_cnt = r_word_cnt;
      // Idle counter saturates instead of wrapping.
      w_idle_inc = (&r_idle) ? r_idle : r_idle + IW'(1);

      case (r_state)
         S_FILL: begin
            if (rinc) begin
               for (int i = 0; i < PACK; i++) begin
                  if (r_count == CW'(i)) begin
                     w_data[i*data_width +: data_width] = rdata;
                     w_keep[i]                          = 1'b1;
                  end
               end
               w_count = r_count + CW'(1);
               w_idle  = '0;
               if (r_count == CW'(PACK - 1)) begin
                  w_state = S_HOLD;
                  w_count = '0;
               end
            end else if ((r_count != '0) && (TIMEOUT != 0)) begin
               w_idle = w_idle_inc;
               if (w_idle_inc == IW'(TIMEOUT)) begin
                  w_state = S_HOLD;
                  w_count = '0;
                  w_idle  = '0;
               end
            end else begin
               w_idle = '0;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               w_word_cnt = r_word_cnt + 16'd1;
               w_state    = S_FILL;
               w_idle     = '0;
               w_data     = '0;
               w_keep     = '0;
               w_count    = '0;
               // Refill lane 0 on the accept edge so a steady stream has no bubble.
               if (!rempty) begin
                  w_data[data_width-1:0] = rdata;
                  w_keep                 = PACK'(1);
                  w_count                = CW'(1);
               end
            end
         end
         default: w_state = S_FILL;
      endcase
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FIFO side driven cycle by cycle, expectations hand-computed.
module tb_fifo_rd_packer;

   logic        rclk;
   logic        r_rst_n;
   logic        rempty;
   logic [7:0]  rdata;
   logic        rinc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic [15:0] word_cnt;

   int n_vec;
   int n_err;

   fifo_rd_packer #(.data_width(8), .PACK(4), .TIMEOUT(16)) dut (
      .rclk      (rclk),
      .r_rst_n   (r_rst_n),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .word_cnt  (word_cnt)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic step;
      @(posedge rclk);
      #1;
   endtask

   task automatic drive(input logic emp, input logic [7:0] d, input logic rdy);
      rempty    = emp;
      rdata     = d;
      out_ready = rdy;
      #1;
   endtask

   task automatic test_reset;
      r_rst_n = 1'b0;
      drive(1'b0, 8'h5A, 1'b1);
      repeat (3) @(posedge rclk);
      #1;
      n_vec++; if (rinc !== 1'b0) begin n_err++; $display("FAIL reset_rinc: got %b exp 0", rinc); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
      n_vec++; if (out_keep !== 4'h0) begin n_err++; $display("FAIL reset_keep: got %h exp 0", out_keep); end
      n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h exp 0", out_data); end
      n_vec++; if (word_cnt !== 16'h0) begin n_err++; $display("FAIL reset_word_cnt: got %h exp 0", word_cnt); end
      drive(1'b1, 8'h00, 1'b1);
      r_rst_n = 1'b1;
      step;
   endtask

   task automatic test_idle_empty;
      drive(1'b1, 8'h00, 1'b1);
      repeat (20) step;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b exp 0", out_valid); end
      n_vec++; if (rinc !== 1'b0) begin n_err++; $display("FAIL idle_rinc: got %b exp 0", rinc); end
   endtask

   task automatic test_full_word;
      logic [7:0] b [4];
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, b[i], 1'b1);
         n_vec++; if (rinc !== 1'b1) begin n_err++; $display("FAIL full_rinc[%0d]: got %b exp 1", i, rinc); end
         step;
      end
      drive(1'b1, 8'h00, 1'b1);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b exp 1", out_valid); end
      n_vec++; if (out_data !== 32'h44332211) begin n_err++; $display("FAIL full_data: got %h exp 44332211", out_data); end
      n_vec++; if (out_keep !== 4'hF) begin n_err++; $display("FAIL full_keep: got %h exp f", out_keep); end
      n_vec++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL full_cnt_pre: got %0d exp 0", word_cnt); end
      step;
      n_vec++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL full_cnt_post: got %0d exp 1", word_cnt); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_valid_drop: got %b exp 0", out_valid); end
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 8'(8'hA1 + i), 1'b0);
         step;
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 8'hB1, 1'b0);
         n_vec++; if (rinc !== 1'b0) begin n_err++; $display("FAIL bp_rinc[%0d]: got %b exp 0", k, rinc); end
         n_vec++; if (out_data !== 32'hA4A3A2A1) begin n_err++; $display("FAIL bp_data[%0d]: got %h exp a4a3a2a1", k, out_data); end
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b exp 1", k, out_valid); end
         step;
      end
      drive(1'b0, 8'hB1, 1'b1);
      n_vec++; if (rinc !== 1'b1) begin n_err++; $display("FAIL bp_accept_rinc: got %b exp 1", rinc); end
      step;
      n_vec++; if (word_cnt !== 16'd2) begin n_err++; $display("FAIL bp_cnt: got %0d exp 2", word_cnt); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b exp 0", out_valid); end
      for (int i = 1; i < 4; i++) begin
         drive(1'b0, 8'(8'hB1 + i), 1'b1);
         step;
      end
      drive(1'b1, 8'h00, 1'b1);
      n_vec++; if (out_data !== 32'hB4B3B2B1) begin n_err++; $display("FAIL bp_refill_data: got %h exp b4b3b2b1", out_data); end
      n_vec++; if (out_keep !== 4'hF) begin n_err++; $display("FAIL bp_refill_keep: got %h exp f", out_keep); end
      step;
      n_vec++; if (word_cnt !== 16'd3) begin n_err++; $display("FAIL bp_cnt2: got %0d exp 3", word_cnt); end
   endtask

   task automatic test_timeout;
      int k_rise;
      drive(1'b0, 8'hAA, 1'b1);
      step;
      drive(1'b0, 8'hBB, 1'b1);
      step;
      drive(1'b1, 8'h00, 1'b1);
      k_rise = 0;
      for (int k = 1; k <= 40 && k_rise == 0; k++) begin
         step;
         if (out_valid) k_rise = k;
      end
      n_vec++; if (k_rise !== 16) begin n_err++; $display("FAIL to_edges: got %0d exp 16", k_rise); end
      n_vec++; if (out_data !== 32'h0000BBAA) begin n_err++; $display("FAIL to_data: got %h exp 0000bbaa", out_data); end
      n_vec++; if (out_keep !== 4'b0011) begin n_err++; $display("FAIL to_keep: got %b exp 0011", out_keep); end
      step;
      n_vec++; if (word_cnt !== 16'd4) begin n_err++; $display("FAIL to_cnt: got %0d exp 4", word_cnt); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL to_valid_drop: got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 8'(i + 1), 1'b1);
         n_vec++; if (rinc !== 1'b1) begin n_err++; $display("FAIL b2b_rinc[%0d]: got %b exp 1", i, rinc); end
         if (i == 4) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid1: got %b exp 1", out_valid); end
            n_vec++; if (out_data !== 32'h04030201) begin n_err++; $display("FAIL b2b_data1: got %h exp 04030201", out_data); end
         end
         step;
         if (i == 4) begin
            n_vec++; if (word_cnt !== 16'd5) begin n_err++; $display("FAIL b2b_cnt1: got %0d exp 5", word_cnt); end
            n_vec++; if (out_keep !== 4'b0001) begin n_err++; $display("FAIL b2b_keep_refill: got %b exp 0001", out_keep); end
         end
      end
      drive(1'b1, 8'h00, 1'b1);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid2: got %b exp 1", out_valid); end
      n_vec++; if (out_data !== 32'h08070605) begin n_err++; $display("FAIL b2b_data2: got %h exp 08070605", out_data); end
      n_vec++; if (out_keep !== 4'hF) begin n_err++; $display("FAIL b2b_keep2: got %h exp f", out_keep); end
      step;
      n_vec++; if (word_cnt !== 16'd6) begin n_err++; $display("FAIL b2b_cnt2: got %0d exp 6", word_cnt); end
   endtask

   task automatic test_reset_mid;
      drive(1'b0, 8'hC1, 1'b1);
      step;
      drive(1'b0, 8'hC2, 1'b1);
      step;
      drive(1'b0, 8'hC3, 1'b1);
      r_rst_n = 1'b0;
      #1;
      n_vec++; if (rinc !== 1'b0) begin n_err++; $display("FAIL rm_rinc: got %b exp 0", rinc); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b exp 0", out_valid); end
      n_vec++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL rm_cnt: got %0d exp 0", word_cnt); end
      step;
      drive(1'b1, 8'h00, 1'b1);
      r_rst_n = 1'b1;
      step;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 8'(8'hD1 + i), 1'b0);
         step;
      end
      drive(1'b1, 8'h00, 1'b0);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_word_valid: got %b exp 1", out_valid); end
      n_vec++; if (out_data !== 32'hD4D3D2D1) begin n_err++; $display("FAIL rm_word_data: got %h exp d4d3d2d1", out_data); end
      n_vec++; if (out_keep !== 4'hF) begin n_err++; $display("FAIL rm_word_keep: got %h exp f", out_keep); end
      drive(1'b1, 8'h00, 1'b1);
      step;
      n_vec++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL rm_word_cnt: got %0d exp 1", word_cnt); end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      r_rst_n   = 1'b0;
      rempty    = 1'b1;
      rdata     = 8'h00;
      out_ready = 1'b0;
      test_reset;
      test_idle_empty;
      test_full_word;
      test_backpressure;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
